sprite_motion_stepper: RTL and testbench
========================================

# sprite_motion_stepper

Moves one on-screen sprite on a 640x480 playfield. Consumes the 1-in-8 enable pulse from the clock-divider stage on `tick`, and direction commands from the keyboard decoder on a valid/ready handshake. Every `TICKS_PER_STEP` ticks it advances the sprite position by `STEP` pixels, clamping at the playfield bounds. Its position outputs feed the sprite/color mapper.

## Interface
- `X_MIN`, default 0: left bound, inclusive.
- `X_MAX`, default 639: right bound, inclusive.
- `Y_MIN`, default 0: top bound, inclusive.
- `Y_MAX`, default 479: bottom bound, inclusive.
- `X_INIT`, default 320: reset x position.
- `Y_INIT`, default 240: reset y position.
- `STEP`, default 1: pixels per move, 1..15.
- `TICKS_PER_STEP`, default 1: ticks per move, 1..16.

Ports:
- `Clk`  in  1  system clock; the only clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `tick`  in  1  one-`Clk`-wide enable pulse from the divider.
- `cmd_valid`  in  1  command present.
- `cmd_dir`  in  3  command code: 0 stop, 1 up, 2 down, 3 left, 4 right; 5–7 reserved.
- `cmd_ready`  out  1  command can be accepted this cycle.
- `pos_x`  out  10  current x position.
- `pos_y`  out  10  current y position.
- `moving`  out  1  state is MOVE.
- `hit_wall`  out  1  one-cycle pulse when a step was clamped.

## Operation
- Two states:
  - STOP: direction register cleared, tick counter held at 0.
  - MOVE: direction register holds 1–4.
- Reset value of every output and register:
  - pos_x=X_INIT, pos_y=Y_INIT.
  - state STOP, moving=0, hit_wall=0, tick counter 0.
- `cmd_ready` is combinational: `!Reset && !tick`. Commands are never accepted in a tick cycle.
- Command acceptance: on a rising edge with `cmd_valid && cmd_ready`.
  - Code 0: go to STOP, counter cleared.
  - Code 1–4 with a new direction (or from STOP): go to MOVE, latch the direction, counter cleared.
  - Code 1–4 equal to the current direction while in MOVE: accepted, no effect; the counter is NOT cleared, so key auto-repeat must not stall motion.
  - Codes 5–7: accepted (consumed) and ignored.
- Tick handling (only in MOVE):
  - If counter == TICKS_PER_STEP-1: perform a step and clear the counter.
  - Otherwise: increment the counter.
- Step arithmetic:
  - Compute in 11-bit signed: candidate = pos ± STEP on the axis of the direction.
  - Up is -y, down +y, left -x, right +x.
  - If the candidate is outside [MIN,MAX], the position becomes the bound, hit_wall pulses, and the state goes to STOP.
  - If the candidate equals the bound exactly, it is not a hit: stay in MOVE.
- Already at a bound and commanded further outward: the next step clamps (position unchanged), hit_wall pulses, and the state goes to STOP.
- Only the direction axis changes; the other coordinate is never modified.

## Timing
- The tick is high in cycle T; the position update, moving, and hit_wall are visible in T+1. hit_wall is high for exactly cycle T+1.
- A command accepted at the edge ending cycle C sets the direction, moving, and counter from C+1.
- The first step after a direction change occurs on the TICKS_PER_STEP-th tick after acceptance.
- Ticks in STOP are ignored; the counter stays 0.
- Reset asserted mid-move: all state returns to reset values immediately (asynchronous), without waiting for `Clk`. After deassertion, operation resumes on the first `Clk` edge.
- Maximum position-update rate is one per tick (one per 8 `Clk` with the current divider).

## Test plan
- Reset with defaults -> pos=(320,240), moving=0, hit_wall=0, cmd_ready=1 whenever tick=0.
- STEP=4, TICKS_PER_STEP=2, cmd right, then 4 ticks -> x=324 after tick 2, 328 after tick 4; y=240; moving=1 throughout.
- X_INIT=637, STEP=4, cmd right, 1 tick -> x=639, hit_wall high for one cycle, moving=0. Further ticks leave x=639. A subsequent cmd left steps to x=635.
- cmd_valid with code 2 held across a tick cycle -> cmd_ready=0 in that cycle, acceptance on the next cycle, the first step downward one step-period later.
- TICKS_PER_STEP=3, moving up, same-direction command repeated every cycle -> steps still every 3 ticks. Code 6 issued -> consumed, no state change. Code 0 -> moving=0 next cycle.
- Reset pulsed between ticks while moving at (400,100) -> outputs return to (320,240), STOP asynchronously; no step on the following tick.

Source files
------------

// File: rtl/sprite_motion_stepper.sv
// Single-sprite motion stepper: accepts direction commands, advances the
// position by STEP pixels every TICKS_PER_STEP ticks, and clamps at the bounds.
module sprite_motion_stepper #(
    parameter int X_MIN          = 0,
    parameter int X_MAX          = 639,
    parameter int Y_MIN          = 0,
    parameter int Y_MAX          = 479,
    parameter int X_INIT         = 320,
    parameter int Y_INIT         = 240,
    parameter int STEP           = 1,
    parameter int TICKS_PER_STEP = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       tick,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_dir,
    output logic       cmd_ready,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       moving,
    output logic       hit_wall
);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_MOVE = 1'b1
    } state_t;

    localparam logic [2:0] DIR_STOP  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_DOWN  = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_RIGHT = 3'd4;

    localparam logic [3:0]        CNT_LAST = 4'(TICKS_PER_STEP - 1);
    localparam logic signed [10:0] STEP_S  = 11'(STEP);
    localparam logic signed [10:0] XLO_S   = 11'(X_MIN);
    localparam logic signed [10:0] XHI_S   = 11'(X_MAX);
    localparam logic signed [10:0] YLO_S   = 11'(Y_MIN);
    localparam logic signed [10:0] YHI_S   = 11'(Y_MAX);

    state_t      state_q, state_d;
    logic [2:0]  dir_q, dir_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [9:0]  pos_x_q, pos_x_d;
    logic [9:0]  pos_y_q, pos_y_d;
    logic        hit_q, hit_d;
    logic [10:0] step_res;
    logic        accept;

    // Returns {clamped, new_pos}; the candidate is formed in 11-bit signed so
    // that underflow below zero is seen as out of range rather than wrapping.
    function automatic logic [10:0] step_axis(
        input logic [9:0]         pos,
        input logic               toward_min,
        input logic signed [10:0] lo,
        input logic signed [10:0] hi
    );
        logic signed [10:0] cand;
        logic [10:0]        res;
        cand = toward_min ? ($signed({1'b0, pos}) - STEP_S)
                          : ($signed({1'b0, pos}) + STEP_S);
        if (cand < lo)      res = {1'b1, lo[9:0]};
        else if (cand > hi) res = {1'b1, hi[9:0]};
        else                res = {1'b0, cand[9:0]};
        return res;
    endfunction

    assign cmd_ready = !Reset && !tick;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        hit_d    = 1'b0;
        step_res = '0;
        if (accept) begin
            case (cmd_dir)
                DIR_STOP: begin
                    state_d = ST_STOP;
                    dir_d   = DIR_STOP;
                    cnt_d   = '0;
                end
                DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT: begin
                    // Repeating the current direction must not restart the step period.
                    if (!(state_q == ST_MOVE && dir_q == cmd_dir)) begin
                        state_d = ST_MOVE;
                        dir_d   = cmd_dir;
                        cnt_d   = '0;
                    end
                end
                default: ;
            endcase
        end else if (tick && state_q == ST_MOVE) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                case (dir_q)
                    DIR_UP:   step_res = step_axis(pos_y_q, 1'b1, YLO_S, YHI_S);
                    DIR_DOWN: step_res = step_axis(pos_y_q, 1'b0, YLO_S, YHI_S);
                    DIR_LEFT: step_res = step_axis(pos_x_q, 1'b1, XLO_S, XHI_S);
                    default:  step_res = step_axis(pos_x_q, 1'b0, XLO_S, XHI_S);
                endcase
                if (dir_q == DIR_UP || dir_q == DIR_DOWN) pos_y_d = step_res[9:0];
                else                                      pos_x_d = step_res[9:0];
                if (step_res[10]) begin
                    hit_d   = 1'b1;
                    state_d = ST_STOP;
                    dir_d   = DIR_STOP;
                end
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_STOP;
            dir_q   <= DIR_STOP;
            cnt_q   <= '0;
            pos_x_q <= 10'(X_INIT);
            pos_y_q <= 10'(Y_INIT);
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            hit_q   <= hit_d;
        end
    end

    assign pos_x    = pos_x_q;
    assign pos_y    = pos_y_q;
    assign moving   = (state_q == ST_MOVE);
    assign hit_wall = hit_q;

endmodule

// File: tb/tb_sprite_motion_stepper.sv
// Bench for sprite_motion_stepper: five differently parameterised instances share
// one stimulus stream; directed tables, hand sequences and random traffic vs a model.
module tb_sprite_motion_stepper;

    localparam int N = 5;
    localparam int P_XMIN [N] = '{0, 0, 0, 0, 10};
    localparam int P_XMAX [N] = '{639, 639, 639, 639, 20};
    localparam int P_YMIN [N] = '{0, 0, 0, 0, 5};
    localparam int P_YMAX [N] = '{479, 479, 479, 479, 12};
    localparam int P_XI   [N] = '{320, 320, 637, 320, 15};
    localparam int P_YI   [N] = '{240, 240, 240, 240, 8};
    localparam int P_STEP [N] = '{1, 4, 4, 1, 3};
    localparam int P_TPS  [N] = '{1, 2, 1, 3, 2};

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       tick = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_dir = 3'd0;
    logic       rdy [N];
    logic [9:0] px  [N];
    logic [9:0] py  [N];
    logic       mv  [N];
    logic       hw  [N];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: dir 0 means stopped; cnt counts ticks since the last step.
    int m_x [N];
    int m_y [N];
    int m_dir [N];
    int m_cnt [N];
    int m_hit [N];

    always #5 Clk = ~Clk;

    sprite_motion_stepper u0 (
        .Clk(Clk), .Reset(Reset), .tick(tick), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
        .cmd_ready(rdy[0]), .pos_x(px[0]), .pos_y(py[0]), .moving(mv[0]), .hit_wall(hw[0]));

    sprite_motion_stepper #(.STEP(4), .TICKS_PER_STEP(2)) u1 (
        .Clk(Clk), .Reset(Reset), .tick(tick), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
        .cmd_ready(rdy[1]), .pos_x(px[1]), .pos_y(py[1]), .moving(mv[1]), .hit_wall(hw[1]));

    sprite_motion_stepper #(.X_INIT(637), .STEP(4), .TICKS_PER_STEP(1)) u2 (
        .Clk(Clk), .Reset(Reset), .tick(tick), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
        .cmd_ready(rdy[2]), .pos_x(px[2]), .pos_y(py[2]), .moving(mv[2]), .hit_wall(hw[2]));

    sprite_motion_stepper #(.STEP(1), .TICKS_PER_STEP(3)) u3 (
        .Clk(Clk), .Reset(Reset), .tick(tick), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
        .cmd_ready(rdy[3]), .pos_x(px[3]), .pos_y(py[3]), .moving(mv[3]), .hit_wall(hw[3]));

    sprite_motion_stepper #(.X_MIN(10), .X_MAX(20), .Y_MIN(5), .Y_MAX(12), .X_INIT(15),
                            .Y_INIT(8), .STEP(3), .TICKS_PER_STEP(2)) u4 (
        .Clk(Clk), .Reset(Reset), .tick(tick), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
        .cmd_ready(rdy[4]), .pos_x(px[4]), .pos_y(py[4]), .moving(mv[4]), .hit_wall(hw[4]));

    typedef struct {
        bit rst;
        int dut;
        bit t;
        bit v;
        int dir;
        int ex;
        int ey;
        bit emov;
        bit ehit;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_x[i] = P_XI[i];
            m_y[i] = P_YI[i];
            m_dir[i] = 0;
            m_cnt[i] = 0;
            m_hit[i] = 0;
        end
    endtask

    // Advance the reference by one clock given the inputs about to be sampled.
    task automatic model_step(input bit t, input bit v, input int d);
        int nx, ny;
        for (int i = 0; i < N; i++) begin
            m_hit[i] = 0;
            if (v && !t) begin
                if (d == 0) begin
                    m_dir[i] = 0;
                    m_cnt[i] = 0;
                end else if (d <= 4 && d != m_dir[i]) begin
                    m_dir[i] = d;
                    m_cnt[i] = 0;
                end
            end else if (t && m_dir[i] != 0) begin
                m_cnt[i]++;
                if (m_cnt[i] == P_TPS[i]) begin
                    m_cnt[i] = 0;
                    nx = m_x[i];
                    ny = m_y[i];
                    case (m_dir[i])
                        1: ny = ny - P_STEP[i];
                        2: ny = ny + P_STEP[i];
                        3: nx = nx - P_STEP[i];
                        default: nx = nx + P_STEP[i];
                    endcase
                    if (nx < P_XMIN[i]) begin nx = P_XMIN[i]; m_hit[i] = 1; end
                    if (nx > P_XMAX[i]) begin nx = P_XMAX[i]; m_hit[i] = 1; end
                    if (ny < P_YMIN[i]) begin ny = P_YMIN[i]; m_hit[i] = 1; end
                    if (ny > P_YMAX[i]) begin ny = P_YMAX[i]; m_hit[i] = 1; end
                    m_x[i] = nx;
                    m_y[i] = ny;
                    if (m_hit[i] != 0) m_dir[i] = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("u%0d.pos_x", i), int'(px[i]), m_x[i]);
            chk($sformatf("u%0d.pos_y", i), int'(py[i]), m_y[i]);
            chk($sformatf("u%0d.moving", i), int'(mv[i]), (m_dir[i] != 0) ? 1 : 0);
            chk($sformatf("u%0d.hit_wall", i), int'(hw[i]), m_hit[i]);
        end
    endtask

    // Drive one cycle's inputs, check cmd_ready before the edge and all outputs after it.
    task automatic cyc(input bit t, input bit v, input logic [2:0] d);
        tick = t;
        cmd_valid = v;
        cmd_dir = d;
        #1;
        for (int i = 0; i < N; i++) chk($sformatf("u%0d.cmd_ready", i), int'(rdy[i]), t ? 0 : 1);
        model_step(t, v, int'(d));
        @(posedge Clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        tick = 1'b0;
        cmd_valid = 1'b0;
        Reset = 1'b1;
        model_reset();
        #3;
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // rst, dut, tick, valid, dir, exp_x, exp_y, exp_moving, exp_hit
        vecs.push_back('{1, 1, 0, 1, 4, 320, 240, 1, 0});
        vecs.push_back('{0, 1, 1, 0, 0, 320, 240, 1, 0});
        vecs.push_back('{0, 1, 1, 0, 0, 324, 240, 1, 0});
        vecs.push_back('{0, 1, 1, 0, 0, 324, 240, 1, 0});
        vecs.push_back('{0, 1, 1, 0, 0, 328, 240, 1, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 328, 240, 1, 0});
        vecs.push_back('{1, 2, 0, 1, 4, 637, 240, 1, 0});
        vecs.push_back('{0, 2, 1, 0, 0, 639, 240, 0, 1});
        vecs.push_back('{0, 2, 0, 0, 0, 639, 240, 0, 0});
        vecs.push_back('{0, 2, 1, 0, 0, 639, 240, 0, 0});
        vecs.push_back('{0, 2, 1, 0, 0, 639, 240, 0, 0});
        vecs.push_back('{0, 2, 0, 1, 4, 639, 240, 1, 0});
        vecs.push_back('{0, 2, 1, 0, 0, 639, 240, 0, 1});
        vecs.push_back('{0, 2, 0, 1, 3, 639, 240, 1, 0});
        vecs.push_back('{0, 2, 1, 0, 0, 635, 240, 1, 0});
        vecs.push_back('{1, 0, 1, 1, 2, 320, 240, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 2, 320, 240, 1, 0});
        vecs.push_back('{0, 0, 1, 0, 0, 320, 241, 1, 0});
        vecs.push_back('{1, 3, 0, 1, 1, 320, 240, 1, 0});
        vecs.push_back('{0, 3, 1, 1, 1, 320, 240, 1, 0});
        vecs.push_back('{0, 3, 0, 1, 1, 320, 240, 1, 0});
        vecs.push_back('{0, 3, 1, 1, 1, 320, 240, 1, 0});
        vecs.push_back('{0, 3, 0, 1, 1, 320, 240, 1, 0});
        vecs.push_back('{0, 3, 1, 1, 1, 320, 239, 1, 0});
        vecs.push_back('{0, 3, 0, 1, 1, 320, 239, 1, 0});
        vecs.push_back('{0, 3, 1, 1, 1, 320, 239, 1, 0});
        vecs.push_back('{0, 3, 0, 1, 1, 320, 239, 1, 0});
        vecs.push_back('{0, 3, 1, 1, 1, 320, 239, 1, 0});
        vecs.push_back('{0, 3, 0, 1, 1, 320, 239, 1, 0});
        vecs.push_back('{0, 3, 1, 1, 1, 320, 238, 1, 0});
        vecs.push_back('{0, 3, 1, 0, 0, 320, 238, 1, 0});
        vecs.push_back('{0, 3, 0, 1, 6, 320, 238, 1, 0});
        vecs.push_back('{0, 3, 1, 0, 0, 320, 238, 1, 0});
        vecs.push_back('{0, 3, 1, 0, 0, 320, 237, 1, 0});
        vecs.push_back('{0, 3, 0, 1, 0, 320, 237, 0, 0});
        vecs.push_back('{0, 3, 1, 0, 0, 320, 237, 0, 0});

        // Asynchronous reset with no clock edge involved.
        #1;
        Reset = 1'b1;
        model_reset();
        #1;
        check_all();
        for (int i = 0; i < N; i++) chk($sformatf("u%0d.ready_in_reset", i), int'(rdy[i]), 0);
        #2;
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        chk("ready_idle", int'(rdy[0]), 1);
        tick = 1'b1;
        #1;
        chk("ready_tick", int'(rdy[0]), 0);
        tick = 1'b0;
        @(posedge Clk);
        #1;
        check_all();

        for (int k = 0; k < vecs.size(); k++) begin
            if (vecs[k].rst) do_reset();
            cyc(vecs[k].t, vecs[k].v, 3'(vecs[k].dir));
            chk($sformatf("vec%0d.x", k), int'(px[vecs[k].dut]), vecs[k].ex);
            chk($sformatf("vec%0d.y", k), int'(py[vecs[k].dut]), vecs[k].ey);
            chk($sformatf("vec%0d.moving", k), int'(mv[vecs[k].dut]), int'(vecs[k].emov));
            chk($sformatf("vec%0d.hit", k), int'(hw[vecs[k].dut]), int'(vecs[k].ehit));
        end

        // Drive u1 to (400,100) while moving up, then reset between ticks.
        do_reset();
        cyc(1'b0, 1'b1, 3'd4);
        repeat (40) cyc(1'b1, 1'b0, 3'd0);
        chk("travel.x", int'(px[1]), 400);
        cyc(1'b0, 1'b1, 3'd1);
        repeat (70) cyc(1'b1, 1'b0, 3'd0);
        chk("travel.y", int'(py[1]), 100);
        chk("travel.moving", int'(mv[1]), 1);
        cyc(1'b0, 1'b0, 3'd0);
        #2;
        Reset = 1'b1;
        model_reset();
        #1;
        chk("midrst.x", int'(px[1]), 320);
        chk("midrst.y", int'(py[1]), 240);
        chk("midrst.moving", int'(mv[1]), 0);
        #2;
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        check_all();
        cyc(1'b1, 1'b0, 3'd0);
        chk("postrst.x", int'(px[1]), 320);
        chk("postrst.y", int'(py[1]), 240);
        chk("postrst.moving", int'(mv[1]), 0);

        // Random traffic against the reference, with occasional async resets.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(299) == 0) begin
                #2;
                Reset = 1'b1;
                model_reset();
                #1;
                chk("rand_rst.x4", int'(px[4]), P_XI[4]);
                chk("rand_rst.moving4", int'(mv[4]), 0);
                #1;
                Reset = 1'b0;
            end
            cyc($urandom_range(2) == 0, $urandom_range(4) == 0, 3'($urandom_range(7)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
